// File: rtl/tick_delay_arbiter.sv
// Round-robin owner of one prescaled down-counter; grant one edge after req, done D*(PRESCALE_MAX+1) clocks after grant.
// Losing requests stay pending at their req level; TICK_DELAY_ABORT_EN lets an owner cancel by dropping req.
module tick_delay_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PRESCALE_MAX  = 49,
  parameter int PRESCALE_SIZE = 6,
  parameter int DELAY_SIZE    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DELAY_SIZE-1:0] delay_ticks,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic                          tick
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1  = IDXW + 1;
  localparam logic [PRESCALE_SIZE-1:0] PMAX = PRESCALE_SIZE'(PRESCALE_MAX);
  localparam logic [IDXW-1:0]          LAST = IDXW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]       ONE  = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDXW-1:0]         winner_q, winner_d;
  logic [IDXW-1:0]         rr_q, rr_d;
  logic [PRESCALE_SIZE-1:0] presc_q, presc_d;
  logic [DELAY_SIZE-1:0]   remaining_q, remaining_d;

  logic [DELAY_SIZE-1:0]   delay_arr [NUM_REQ];
  logic                    any_req;
  logic [IDXW-1:0]         win_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign delay_arr[g] = delay_ticks[g*DELAY_SIZE +: DELAY_SIZE];
  end

  // Scan downward so the requester closest to rr_q is the last (winning) match.
  always_comb begin : arb
    logic [IW1-1:0] idx;
    any_req = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + IW1'(i);
      if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
      if (req[idx[IDXW-1:0]]) begin
        any_req = 1'b1;
        win_idx = idx[IDXW-1:0];
      end
    end
  end

  assign tick  = (state_q == COUNT) && (presc_q == PMAX);
  assign busy  = (state_q != IDLE);
  assign grant = grant_q;
  assign done  = (state_q == DONE) ? grant_q : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    winner_d    = winner_q;
    rr_d        = rr_q;
    presc_d     = '0;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d     = ONE << win_idx;
          winner_d    = win_idx;
          remaining_d = delay_arr[win_idx];
          rr_d        = (win_idx == LAST) ? '0 : win_idx + IDXW'(1);
          state_d     = (delay_arr[win_idx] == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
`ifdef TICK_DELAY_ABORT_EN
        if (!req[winner_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else
`endif
        begin
          presc_d = tick ? '0 : presc_q + PRESCALE_SIZE'(1);
          if (tick) begin
            remaining_d = remaining_q - DELAY_SIZE'(1);
            if (remaining_q == DELAY_SIZE'(1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      winner_q    <= '0;
      rr_q        <= '0;
      presc_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      winner_q    <= winner_d;
      rr_q        <= rr_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_tick_delay_arbiter.sv
// Randomised scoreboard bench for tick_delay_arbiter with a timeline model of grants, ticks and done pulses.
`timescale 1ns/1ps
module tb_tick_delay_arbiter;
  localparam int NR = 4;
  localparam int PM = 4;
  localparam int PS = 3;
  localparam int DW = 8;
  localparam int TP = PM + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] delay_ticks;
  logic [NR-1:0]    grant, done;
  logic             busy, tick;
  logic [DW-1:0]    dly [NR];

  always #5 clk = ~clk;

  always_comb begin
    delay_ticks = '0;
    for (int i = 0; i < NR; i++) delay_ticks[i*DW +: DW] = dly[i];
  end

  tick_delay_arbiter #(.NUM_REQ(NR), .PRESCALE_MAX(PM), .PRESCALE_SIZE(PS), .DELAY_SIZE(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .delay_ticks(delay_ticks),
    .grant(grant), .done(done), .busy(busy), .tick(tick)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int done_cyc; } exp_t;
  exp_t sb_q[$];

  // Reference timeline: one owner window [g, endc]; timer free again from idle_from.
  bit            act = 1'b0;
  int            own = 0, g = 0, dd = 0, endc = 0, idle_from = 0, rr = 0;
  logic [NR-1:0] last_done = '0;
  bit            agent_en = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin : model
    logic [NR-1:0] eg;
    bit            et;
    bit            found;
    int            w, idx;
    last_done = done;
    if (reset) begin
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tick", int'(tick), 0);
      act = 1'b0;
      sb_q.delete();
      rr = 0;
      idle_from = cyc + 1;
    end else begin
      eg = (act && cyc >= g && cyc <= endc) ? (NR'(1) << own) : '0;
      et = act && dd > 0 && cyc >= g && cyc < g + dd*TP && cyc <= endc && ((cyc - g) % TP == TP - 1);
      chk("grant", int'(grant), int'(eg));
      chk("busy", int'(busy), int'(eg != '0));
      chk("tick", int'(tick), int'(et));
`ifdef TICK_DELAY_ABORT_EN
      if (act && dd > 0 && cyc >= g && cyc < g + dd*TP && cyc <= endc && !req[own]) begin
        endc = cyc;
        idle_from = cyc + 1;
        void'(sb_q.pop_back());
      end
`endif
      if (cyc >= idle_from && req != '0) begin
        found = 1'b0;
        w = 0;
        for (int k = 0; k < NR; k++) begin
          idx = (rr + k) % NR;
          if (req[idx] && !found) begin
            found = 1'b1;
            w = idx;
          end
        end
        act = 1'b1;
        own = w;
        g = cyc + 1;
        dd = int'(dly[w]);
        endc = g + dd*TP;
        idle_from = endc + 1;
        rr = (w + 1) % NR;
        sb_q.push_back('{id: w, done_cyc: endc});
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (done != '0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected cyc=%0d got=%0h expected=none", cyc, done);
        end else begin
          e = sb_q.pop_front();
          chk("done_id", int'(done), int'(NR'(1) << e.id));
          chk("done_cyc", cyc, e.done_cyc);
        end
      end else if (sb_q.size() > 0 && sb_q[0].done_cyc <= cyc) begin
        e = sb_q.pop_front();
        chk("done_missing", 0, int'(NR'(1) << e.id));
      end
    end
  end

  function automatic logic [DW-1:0] rand_d();
    if ($urandom_range(0, 7) == 0) return DW'($urandom_range(4, 10));
    return DW'($urandom_range(0, 3));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (last_done[i]) req[i] = 1'b0;
      else if (agent_en) begin
        if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          dly[i] = rand_d();
        end
      end
    end
    if (agent_en && $urandom_range(0, 3) == 0) dly[$urandom_range(0, NR-1)] = rand_d();
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int k = 0; k < max_cyc; k++) begin
      step();
      if (req == '0 && !busy && sb_q.size() == 0) begin
        checks++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout cyc=%0d got=busy expected=idle within %0d cycles", name, cyc, max_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) dly[i] = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    step(); dly[0] = 8'd3; req[0] = 1'b1;
    wait_idle(100, "single_d3");

    step(); for (int i = 0; i < NR; i++) dly[i] = 8'd1; req = '1;
    wait_idle(200, "all_four");

    step(); dly[2] = 8'd0; req[2] = 1'b1;
    wait_idle(20, "zero_delay");

    step(); dly[1] = '1; req[1] = 1'b1;
    wait_idle(1400, "max_delay");

    dly[1] = 8'd1; dly[3] = 8'd2;
    for (int k = 0; k < 80; k++) begin
      step();
      if (!last_done[1]) req[1] = 1'b1;
      if (!last_done[3]) req[3] = 1'b1;
    end
    step(); req = '0;
    wait_idle(100, "alternate");

    step(); dly[0] = 8'd4; req[0] = 1'b1;
    for (int k = 0; k < 5 && grant == '0; k++) step();
    repeat (7) step();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_grant", int'(grant), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_tick", int'(tick), 0);
    req[3] = 1'b1; dly[3] = 8'd1;
    step(); step();
    #1 reset = 1'b0;
    wait_idle(200, "after_reset");

    agent_en = 1'b1;
    repeat (4000) step();
    agent_en = 1'b0;
    wait_idle(2000, "drain");
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
